rstn_synchronizer: RTL and testbench



---
 rtl/rstn_synchronizer.sv | 86 ++++++++
 tb/tb_rstn_synchronizer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rstn_synchronizer.sv
// Active-low reset synchronizer: asserts asynchronously with rstn, releases synchronously
// to clk after SYNC_STAGES edges plus an optional HOLD_CYCLES stretch.
module rstn_synchronizer #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 0,
   parameter bit RST_INIT    = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   output logic tap_rstn_sync
);

   // rst_q is the last stage of the release chain, so the shift chain itself is one flop shorter.
   localparam int CHAIN_W = (SYNC_STAGES > 2) ? SYNC_STAGES - 1 : 1;

   (* async_reg = "true", dont_retime = "true", init = RST_INIT *)
   logic [CHAIN_W-1:0] sync_q;
   logic [CHAIN_W-1:0] sync_d;
   (* async_reg = "true", dont_retime = "true", init = RST_INIT *)
   logic               rst_q;
   logic               rst_d;
   logic               chain_done;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_stages
      $error("rstn_synchronizer: SYNC_STAGES must be in 2..8");
   end
   if (HOLD_CYCLES < 0 || HOLD_CYCLES > 65535) begin : g_bad_hold
      $error("rstn_synchronizer: HOLD_CYCLES must be in 0..65535");
   end
   if (RST_INIT) begin : g_init_released
      $warning("rstn_synchronizer: RST_INIT=1, flops configure out of reset");
   end

   always_comb begin
      sync_d    = '0;
      sync_d[0] = 1'b1;
      for (int i = 1; i < CHAIN_W; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign chain_done = sync_q[CHAIN_W-1];

   if (HOLD_CYCLES == 0) begin : g_no_hold
      always_comb begin
         rst_d = rst_q | chain_done;
      end
   end else begin : g_hold
      localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
      localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(HOLD_CYCLES);

      logic [HCNT_W-1:0] hcnt_q;
      logic [HCNT_W-1:0] hcnt_d;

      always_comb begin
         hcnt_d = hcnt_q;
         if (chain_done && (hcnt_q < HOLD_MAX)) begin
            hcnt_d = hcnt_q + 1'b1;
         end
         rst_d = rst_q | (chain_done && (hcnt_q == HOLD_MAX));
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            hcnt_q <= '0;
         end else begin
            hcnt_q <= hcnt_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
         rst_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         rst_q  <= rst_d;
      end
   end

   assign tap_rstn_sync = rst_q;

   a_no_rise_in_reset: assert property (@(posedge clk) $rose(tap_rstn_sync) |-> rstn);

endmodule

// File: tb/tb_rstn_synchronizer.sv
// Directed bench for rstn_synchronizer: default instance plus a 3-stage / 4-hold instance,
// checked against an edge-counting model on every falling clk edge.
`timescale 1ns/1ps
module tb_rstn_synchronizer;

   logic   clk    = 1'b0;
   logic   clk_en = 1'b1;
   logic   rstn   = 1'b1;
   logic   tap_a;
   logic   tap_b;
   int     total  = 0;
   int     bad    = 0;

   longint edge_t [16] = '{default: -1};
   int     wptr   = 0;
   longint t_rise = 0;

   rstn_synchronizer #(.SYNC_STAGES(2), .HOLD_CYCLES(0), .RST_INIT(1'b0)) dut_a (
      .clk           (clk),
      .rstn          (rstn),
      .tap_rstn_sync (tap_a)
   );

   rstn_synchronizer #(.SYNC_STAGES(3), .HOLD_CYCLES(4), .RST_INIT(1'b0)) dut_b (
      .clk           (clk),
      .rstn          (rstn),
      .tap_rstn_sync (tap_b)
   );

   always #5 clk = clk_en ? ~clk : 1'b0;

   // Model inputs: time of every recent rising clk edge and of the latest rstn rise.
   always @(posedge clk) begin
      edge_t[wptr] = longint'($time);
      wptr = (wptr + 1) % 16;
   end

   always @(posedge rstn) t_rise = longint'($time);

   task automatic check(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Output must be high once lat edges have sampled rstn high since its last rise.
   // An edge in the same timestep as the rise may or may not count: 2 means either value is legal.
   function automatic int model_out(input int lat);
      int strict_n = 0;
      int incl_n   = 0;
      if (rstn !== 1'b1) return 0;
      for (int i = 0; i < 16; i++) begin
         if (edge_t[i] >  t_rise) strict_n++;
         if (edge_t[i] >= t_rise) incl_n++;
      end
      if (strict_n >= lat) return 1;
      if (incl_n < lat) return 0;
      return 2;
   endfunction

   always @(negedge clk) begin
      int ea;
      int eb;
      ea = model_out(2);
      eb = model_out(7);
      if (ea != 2) check("model_a", tap_a, ea[0]);
      if (eb != 2) check("model_b", tap_b, eb[0]);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lo;
      int hi;

      // Power-up with rstn already high
      #1;
      check("pwrup_a_init", tap_a, 1'b0);
      check("pwrup_b_init", tap_b, 1'b0);
      step();
      check("pwrup_a_e1", tap_a, 1'b0);
      step();
      check("pwrup_a_e2", tap_a, 1'b1);
      $display("power-up release: tap_a=%b", tap_a);

      // Held reset, release between edges; both instances counted edge by edge
      rstn = 1'b0;
      #1;
      check("hold_a_assert", tap_a, 1'b0);
      check("hold_b_assert", tap_b, 1'b0);
      repeat (5) step();
      check("hold_a_in_reset", tap_a, 1'b0);
      rstn = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         check("rel_a_edge", tap_a, (e >= 2) ? 1'b1 : 1'b0);
         check("rel_b_edge", tap_b, (e >= 7) ? 1'b1 : 1'b0);
         $display("release edge %0d: tap_a=%b tap_b=%b", e, tap_a, tap_b);
      end
      repeat (92) step();
      check("steady_a", tap_a, 1'b1);
      check("steady_b", tap_b, 1'b1);

      // Short rstn pulse with the clock stopped
      clk_en = 1'b0;
      #12;
      rstn = 1'b0;
      #0.5;
      check("stopped_a_assert", tap_a, 1'b0);
      check("stopped_b_assert", tap_b, 1'b0);
      #0.5;
      rstn = 1'b1;
      #1;
      check("stopped_a_still0", tap_a, 1'b0);
      clk_en = 1'b1;
      step();
      check("restart_a_e1", tap_a, 1'b0);
      step();
      check("restart_a_e2", tap_a, 1'b1);
      $display("stopped-clock pulse: tap_a=%b", tap_a);

      // Glitch in the middle of a release
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
      step();
      check("glitch_a_e1", tap_a, 1'b0);
      rstn = 1'b0;
      #1;
      check("glitch_a_low", tap_a, 1'b0);
      #1;
      rstn = 1'b1;
      step();
      check("glitch_a_e1_again", tap_a, 1'b0);
      step();
      check("glitch_a_e2_again", tap_a, 1'b1);
      $display("mid-release glitch: tap_a=%b", tap_a);

      // rstn switched in the same timestep as a rising clk edge
      for (int it = 0; it < 50; it++) begin
         @(posedge clk);
         rstn = 1'b0;
         #1;
         check("sync_fall_a", tap_a, 1'b0);
         check("sync_fall_b", tap_b, 1'b0);
         lo = $urandom_range(1, 3);
         repeat (lo) @(posedge clk);
         rstn = 1'b1;
         #1;
         check("sync_rise_a", tap_a, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         check("sync_released_a", tap_a, 1'b1);
         hi = $urandom_range(10, 20);
         repeat (hi - 3) @(posedge clk);
         $display("edge-aligned toggle %0d: low=%0d high=%0d tap_a=%b tap_b=%b",
                  it, lo, hi, tap_a, tap_b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
